pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_if.sv | 31 +++
 rtl/pipeline_hazard_controller.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline hazard inputs, stall/flush controls, status and counters.
interface pipeline_hazard_controller_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_ex_rd;
  logic        id_ex_MemRead;
  logic        ex_branch_taken;
  logic        mem_access;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        pipe_freeze;
  logic        mem_error;
  logic [1:0]  state;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_ex_rd, id_ex_MemRead, ex_branch_taken, mem_access, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_error, state,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_ex_rd, id_ex_MemRead, ex_branch_taken, mem_access, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_error, state,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and memory-wait freezes
// with a timeout abort, plus saturating stall/flush statistics.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StFlush     = 2'd2,
    StMemWait   = 2'd3
  } state_e;

  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_error_q;
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  logic load_use, mem_stall;
  logic err_set, flush_inc;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze;

  assign load_use = bus.id_ex_MemRead && (bus.id_ex_rd != 5'd0) &&
                    ((bus.id_ex_rd == bus.id_rs1) || (bus.id_ex_rd == bus.id_rs2));
  assign mem_stall = bus.mem_access && !bus.mem_ready;

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = state_q;
    wait_d      = wait_q;
    err_set     = 1'b0;
    flush_inc   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == StMemWait) begin
      if (bus.mem_ready) begin
        state_d = StRun;
        wait_d  = 8'd0;
      end else if (wait_q >= TimeoutVal) begin
        // Abort the access: release the pipeline and latch the error.
        err_set = 1'b1;
        state_d = StRun;
        wait_d  = 8'd0;
      end else begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_freeze = 1'b1;
        wait_d      = wait_q + 8'd1;
      end
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
      state_d     = StMemWait;
      wait_d      = 8'd1;
    end else if (state_q == StFlush) begin
      // IF/ID holds a NOP, so branch and load-use hazards are stale here.
      state_d = StRun;
    end else if (bus.ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_inc   = 1'b1;
      state_d     = StFlush;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = StLoadStall;
    end else begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      wait_q      <= 8'd0;
      mem_error_q <= 1'b0;
      stall_q     <= 32'd0;
      flush_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (err_set) begin
        mem_error_q <= 1'b1;
      end
      if (!pc_write && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (flush_inc && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.pipe_freeze  = pipe_freeze;
  assign bus.mem_error    = mem_error_q;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with MEM_TIMEOUT=4.
module tb_pipeline_hazard_controller;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pipeline_hazard_controller_if bus ();

  pipeline_hazard_controller #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs1          = 5'd0;
    bus.id_rs2          = 5'd0;
    bus.id_ex_rd        = 5'd0;
    bus.id_ex_MemRead   = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_access      = 1'b0;
    bus.mem_ready       = 1'b0;
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    reset = 1'b1;
    bus.mem_access = 1'b1;  // stall request must be ignored during reset
    #2;
    check("rst_pc_write", {31'd0, bus.pc_write}, 32'd0);
    check("rst_if_id_write", {31'd0, bus.if_id_write}, 32'd0);
    check("rst_if_id_flush", {31'd0, bus.if_id_flush}, 32'd1);
    check("rst_id_ex_flush", {31'd0, bus.id_ex_flush}, 32'd1);
    check("rst_freeze", {31'd0, bus.pipe_freeze}, 32'd0);
    tick();
    tick();
    check("rst_state", {30'd0, bus.state}, 32'd0);
    check("rst_stall", bus.stall_cycles, 32'd0);
    reset = 1'b0;
    idle();
    @(negedge clk);
    check("idle_pc_write", {31'd0, bus.pc_write}, 32'd1);
    check("idle_if_id_flush", {31'd0, bus.if_id_flush}, 32'd0);

    // Load-use on rs2
    tick();
    bus.id_ex_MemRead = 1'b1;
    bus.id_ex_rd      = 5'd5;
    bus.id_rs1        = 5'd3;
    bus.id_rs2        = 5'd5;
    @(negedge clk);
    check("lu_pc_write", {31'd0, bus.pc_write}, 32'd0);
    check("lu_if_id_write", {31'd0, bus.if_id_write}, 32'd0);
    check("lu_id_ex_flush", {31'd0, bus.id_ex_flush}, 32'd1);
    check("lu_if_id_flush", {31'd0, bus.if_id_flush}, 32'd0);
    tick();
    idle();
    check("lu_state1", {30'd0, bus.state}, 32'd1);
    @(negedge clk);
    check("lu_release", {31'd0, bus.pc_write}, 32'd1);
    tick();
    check("lu_state0", {30'd0, bus.state}, 32'd0);
    check("lu_stall", bus.stall_cycles, 32'd1);

    // Load to x0 never stalls
    bus.id_ex_MemRead = 1'b1;
    @(negedge clk);
    check("rd0_pc_write", {31'd0, bus.pc_write}, 32'd1);
    tick();
    idle();
    check("rd0_state", {30'd0, bus.state}, 32'd0);
    check("rd0_stall", bus.stall_cycles, 32'd1);

    // Branch and load-use together: branch wins
    bus.ex_branch_taken = 1'b1;
    bus.id_ex_MemRead   = 1'b1;
    bus.id_ex_rd        = 5'd7;
    bus.id_rs1          = 5'd7;
    @(negedge clk);
    check("br_if_id_flush", {31'd0, bus.if_id_flush}, 32'd1);
    check("br_id_ex_flush", {31'd0, bus.id_ex_flush}, 32'd1);
    check("br_pc_write", {31'd0, bus.pc_write}, 32'd1);
    tick();
    check("br_state", {30'd0, bus.state}, 32'd2);
    check("br_flush_count", {16'd0, bus.flush_count}, 32'd1);
    @(negedge clk);
    check("fl_pc_write", {31'd0, bus.pc_write}, 32'd1);
    check("fl_id_ex_flush", {31'd0, bus.id_ex_flush}, 32'd0);
    check("fl_if_id_flush", {31'd0, bus.if_id_flush}, 32'd0);
    tick();
    idle();
    check("fl_state", {30'd0, bus.state}, 32'd0);
    check("fl_flush_count", {16'd0, bus.flush_count}, 32'd1);
    check("fl_stall", bus.stall_cycles, 32'd1);

    // Memory wait released after three low-ready cycles
    bus.mem_access = 1'b1;
    @(negedge clk);
    check("mw_freeze0", {31'd0, bus.pipe_freeze}, 32'd1);
    for (int i = 1; i < 3; i++) begin
      tick();
      check("mw_state", {30'd0, bus.state}, 32'd3);
      @(negedge clk);
      check("mw_freeze", {31'd0, bus.pipe_freeze}, 32'd1);
    end
    tick();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("mw_rel_freeze", {31'd0, bus.pipe_freeze}, 32'd0);
    check("mw_rel_pc_write", {31'd0, bus.pc_write}, 32'd1);
    tick();
    idle();
    check("mw_rel_state", {30'd0, bus.state}, 32'd0);
    check("mw_stall", bus.stall_cycles, 32'd4);
    check("mw_no_error", {31'd0, bus.mem_error}, 32'd0);

    // Timeout: four wait cycles with ready held low
    bus.mem_access = 1'b1;
    @(negedge clk);
    check("to_freeze0", {31'd0, bus.pipe_freeze}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("to_state", {30'd0, bus.state}, 32'd3);
      @(negedge clk);
      check("to_freeze", {31'd0, bus.pipe_freeze}, 32'd1);
    end
    tick();
    check("to_state4", {30'd0, bus.state}, 32'd3);
    @(negedge clk);
    check("to_abort_freeze", {31'd0, bus.pipe_freeze}, 32'd0);
    check("to_abort_pc_write", {31'd0, bus.pc_write}, 32'd1);
    check("to_err_pending", {31'd0, bus.mem_error}, 32'd0);
    tick();
    idle();
    check("to_error", {31'd0, bus.mem_error}, 32'd1);
    check("to_state_run", {30'd0, bus.state}, 32'd0);
    check("to_stall", bus.stall_cycles, 32'd8);
    repeat (3) tick();
    check("to_sticky", {31'd0, bus.mem_error}, 32'd1);

    // Asynchronous reset mid-MEM_WAIT
    bus.mem_access = 1'b1;
    tick();
    check("rmw_state3", {30'd0, bus.state}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("rmw_state", {30'd0, bus.state}, 32'd0);
    check("rmw_stall", bus.stall_cycles, 32'd0);
    check("rmw_flush", {16'd0, bus.flush_count}, 32'd0);
    check("rmw_error", {31'd0, bus.mem_error}, 32'd0);
    check("rmw_freeze", {31'd0, bus.pipe_freeze}, 32'd0);
    tick();
    check("rmw_hold_stall", bus.stall_cycles, 32'd0);
    reset = 1'b0;
    idle();
    @(negedge clk);
    check("rmw_after_pc_write", {31'd0, bus.pc_write}, 32'd1);
    check("rmw_after_state", {30'd0, bus.state}, 32'd0);

    // Asynchronous reset mid-LOAD_STALL
    tick();
    bus.id_ex_MemRead = 1'b1;
    bus.id_ex_rd      = 5'd9;
    bus.id_rs1        = 5'd9;
    tick();
    check("rls_state1", {30'd0, bus.state}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rls_state", {30'd0, bus.state}, 32'd0);
    check("rls_stall", bus.stall_cycles, 32'd0);
    tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    check("rls_after_pc_write", {31'd0, bus.pc_write}, 32'd1);
    check("rls_after_flush", {31'd0, bus.id_ex_flush}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
